// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port data RAM between the instruction-fetch port (read only)
//   and the MEM-stage port (load/store). Only one transaction is in flight at a time.
//   Each transaction runs IDLE -> ACCESS -> (WAIT -> RESP) -> IDLE.
//
// Optional build macro: MEM_ARB_RR_EN
//   Defined   : round-robin between the two ports on simultaneous requests.
//   Undefined : fixed priority, where the MEM port wins.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   if_req/if_addr                fetch request; if_gnt is the combinational accept
//   if_done/if_rdata              1-cycle done pulse; registered read data
//   mem_req/mem_we/mem_addr/mem_wdata   load/store request; mem_gnt is the accept
//   mem_done/mem_rdata            done pulse (load data valid or store issued); load data
//   ram_addr_mem/ram_data_mem     RAM address and write data, non-zero only in ACCESS
//   ram_read_enable/ram_write_enable   RAM strobes, active only in ACCESS
//   ram_data                      RAM read data, valid RAM_LATENCY cycles after the strobe
//   stall_if/stall_mem            request outstanding and not yet done
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RAM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] ram_addr_mem,
  output logic [DATA_W-1:0] ram_data_mem,
  output logic              ram_read_enable,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_data,
  output logic              stall_if,
  output logic              stall_mem
);

  generate
    if (RAM_LATENCY < 1 || RAM_LATENCY > 15) begin : g_bad_latency
      $error("mem_port_arbiter: RAM_LATENCY must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t     state;
  logic       owner_mem;  // 1 = MEM port owns the transaction, 0 = fetch
  logic       we_q;
  logic [3:0] cnt;
  logic       idle;
  logic       pick_mem;

  // Gate grants with reset_n so that nothing is accepted while reset is held.
  assign idle = reset_n && (state == IDLE);

`ifdef MEM_ARB_RR_EN
  logic last_mem;  // last grant went to the MEM port; reset value means fetch
  assign pick_mem = mem_req && (!if_req || !last_mem);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                last_mem <= 1'b0;
    else if (mem_gnt || if_gnt)  last_mem <= mem_gnt;
  end
`else
  assign pick_mem = mem_req;
`endif

  assign mem_gnt   = idle && pick_mem;
  assign if_gnt    = idle && if_req && !pick_mem;
  assign stall_if  = reset_n && if_req  && !if_done;
  assign stall_mem = reset_n && mem_req && !mem_done;

  // The RAM-side outputs and the done pulses are registered. They are loaded on
  // the edge that enters the state where they must be visible. The registered
  // address and data also hold the latched request for the ACCESS cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      owner_mem        <= 1'b0;
      we_q             <= 1'b0;
      cnt              <= '0;
      if_done          <= 1'b0;
      mem_done         <= 1'b0;
      if_rdata         <= '0;
      mem_rdata        <= '0;
      ram_addr_mem     <= '0;
      ram_data_mem     <= '0;
      ram_read_enable  <= 1'b0;
      ram_write_enable <= 1'b0;
    end else begin
      if_done          <= 1'b0;
      mem_done         <= 1'b0;
      ram_addr_mem     <= '0;
      ram_data_mem     <= '0;
      ram_read_enable  <= 1'b0;
      ram_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_gnt || if_gnt) begin
            owner_mem    <= mem_gnt;
            we_q         <= mem_gnt && mem_we;
            ram_addr_mem <= mem_gnt ? mem_addr  : if_addr;
            ram_data_mem <= mem_gnt ? mem_wdata : '0;
            if (mem_gnt && mem_we) begin
              ram_write_enable <= 1'b1;
              mem_done         <= 1'b1;  // a store completes in its ACCESS cycle
            end else begin
              ram_read_enable  <= 1'b1;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          cnt   <= 4'(RAM_LATENCY);
          state <= we_q ? IDLE : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (owner_mem) begin
              mem_rdata <= ram_data;
              mem_done  <= 1'b1;
            end else begin
              if_rdata  <= ram_data;
              if_done   <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. A timeline model predicts every output on
// every cycle. It uses the cycle offset from each grant, which fixes when the
// strobes, the capture and the done pulse occur. Literal checks pin the model
// to the documented latencies for L=2.
module tb_mem_port_arbiter;
  localparam int L = 2;

  logic        clk, reset_n;
  logic        if_req, if_gnt, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] ram_addr_mem, ram_data_mem, ram_data;
  logic        ram_read_enable, ram_write_enable, stall_if, stall_mem;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LATENCY(L)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_addr_mem(ram_addr_mem), .ram_data_mem(ram_data_mem),
    .ram_read_enable(ram_read_enable), .ram_write_enable(ram_write_enable),
    .ram_data(ram_data), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, now = 0;

  // model state: one transaction described by its grant cycle
  bit          busy = 0, m_mem = 0, m_we = 0, last_mem = 0;
  int          t_g = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_ird = 0, m_mrd = 0;

  // observed event cycles (pins)
  int mg_c = -1, md_c = -1, ig_c = -1, id_c = -1, re_c = -1, id_n = 0;
  bit hold_mem = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, now, a, e);
    end
  endtask

  task automatic step();
    int rel; bit acc, st, pref_mem;
    logic e_ig, e_mg, e_re, e_we, e_id, e_md, e_si, e_sm;
    logic [31:0] e_ra, e_rwd, e_ird, e_mrd;
    rel = cyc - t_g;
    acc = busy && rel == 1;
    st  = busy && m_mem && m_we;
`ifdef MEM_ARB_RR_EN
    pref_mem = !last_mem;
`else
    pref_mem = 1'b1;
`endif
    e_re  = acc && !st;
    e_we  = acc && st;
    e_ra  = acc ? m_addr  : 32'h0;
    e_rwd = acc ? m_wdata : 32'h0;
    e_md  = busy && m_mem && (st ? rel == 1 : rel == L + 2);
    e_id  = busy && !m_mem && rel == L + 2;
    e_mg  = !busy && mem_req && (!if_req || pref_mem);
    e_ig  = !busy && if_req && !e_mg;
    e_si  = if_req && !e_id;
    e_sm  = mem_req && !e_md;
    e_ird = m_ird;
    e_mrd = m_mrd;
    if (!reset_n) begin
      {e_ig, e_mg, e_re, e_we, e_id, e_md, e_si, e_sm} = '0;
      e_ra = 0; e_rwd = 0; e_ird = 0; e_mrd = 0;
    end
    chk("if_gnt", if_gnt, e_ig);       chk("mem_gnt", mem_gnt, e_mg);
    chk("ram_re", ram_read_enable, e_re); chk("ram_we", ram_write_enable, e_we);
    chk("ram_addr", ram_addr_mem, e_ra);  chk("ram_wdata", ram_data_mem, e_rwd);
    chk("if_done", if_done, e_id);     chk("mem_done", mem_done, e_md);
    chk("stall_if", stall_if, e_si);   chk("stall_mem", stall_mem, e_sm);
    chk("if_rdata", if_rdata, e_ird);  chk("mem_rdata", mem_rdata, e_mrd);
    if (!reset_n) begin
      busy = 0; m_ird = 0; m_mrd = 0; last_mem = 0;
    end else begin
      if (busy && !st && rel == L + 1) begin
        if (m_mem) m_mrd = ram_data; else m_ird = ram_data;
      end
      if (busy && (st ? rel == 1 : rel == L + 2)) busy = 0;
      else if (!busy && (e_mg || e_ig)) begin
        busy = 1; t_g = cyc; m_mem = e_mg; m_we = e_mg && mem_we;
        m_addr = e_mg ? mem_addr : if_addr;
        m_wdata = e_mg ? mem_wdata : 32'h0;
        last_mem = e_mg;
      end
    end
    cyc++;
  endtask

  task automatic cyc_chk();
    @(negedge clk);
    now = cyc;
    if (mem_gnt) mg_c = cyc;
    if (mem_done) md_c = cyc;
    if (if_gnt) ig_c = cyc;
    if (if_done) begin id_c = cyc; id_n++; end
    if (ram_read_enable) re_c = cyc;
    step();
  endtask

  task automatic adv();
    @(posedge clk); #1;
    ram_data = {16'hC0DE, cyc[15:0]};
  endtask

  task automatic t(); cyc_chk(); adv(); endtask

  // run n cycles, dropping each request once it has been granted
  task automatic run(input int n);
    logic gm, gi;
    for (int i = 0; i < n; i++) begin
      cyc_chk(); gm = mem_gnt; gi = if_gnt; adv();
      if (gm && !hold_mem) mem_req = 0;
      if (gi) if_req = 0;
    end
  endtask

  int base, n, g1, g2, d1, dn0;

  initial begin
    reset_n = 0; if_req = 1; mem_req = 1; mem_we = 0;
    if_addr = 32'h4; mem_addr = 32'h8; mem_wdata = 0; ram_data = 0;
    // 1. reset held with both requests present
    for (int i = 0; i < 3; i++) begin
      cyc_chk();
      chk("rst_quiet", {if_gnt, mem_gnt, stall_if, stall_mem, ram_read_enable}, 0);
      adv();
    end
    reset_n = 1; base = cyc;
    run(16);
    chk("rst_first_gnt", mg_c, base);
    chk("rst_then_if", ig_c - mg_c, 5);

    // 2. store; address/data changes after the grant must not leak
    mem_req = 1; mem_we = 1; mem_addr = 32'h10; mem_wdata = 32'hDEADBEEF;
    cyc_chk();
    chk("st_gnt", mem_gnt, 1); chk("st_stall0", stall_mem, 1);
    adv(); mem_addr = 32'h99; mem_wdata = 32'h12345678;
    cyc_chk();
    chk("st_we", ram_write_enable, 1); chk("st_addr", ram_addr_mem, 32'h10);
    chk("st_data", ram_data_mem, 32'hDEADBEEF); chk("st_done", mem_done, 1);
    chk("st_stall1", stall_mem, 0);
    adv(); mem_req = 0; mem_we = 0;
    run(2);

    // 3. fetch, L=2: enable @1, data driven @3, done @4
    if_req = 1; if_addr = 32'h40;
    cyc_chk(); base = now; chk("f_gnt", if_gnt, 1);
    adv(); if_req = 0;
    t(); chk("f_re_at1", re_c - base, 1);
    t(); ram_data = 32'h00500093;
    t(); t();
    chk("f_done_at4", id_c - base, 4);
    run(3);
    chk("f_rdata_held", if_rdata, 32'h00500093);

    // 4. simultaneous load + fetch
    mem_req = 1; mem_we = 0; mem_addr = 32'h80; mem_wdata = 0;
    if_req = 1; if_addr = 32'h44; base = cyc;
    run(16);
`ifndef MEM_ARB_RR_EN
    chk("col_mem_first", mg_c - base, 0);
    chk("col_mem_done", md_c - mg_c, 4);
    chk("col_if_gnt", ig_c - mg_c, 5);
    chk("col_if_done", id_c - ig_c, 4);
`endif

    // 5. reset while the fetch waits on the RAM
    if_req = 1; if_addr = 32'h48;
    cyc_chk(); adv(); if_req = 0;
    t();
    reset_n = 0;
    cyc_chk();
    chk("midrst_rdata", if_rdata, 0); chk("midrst_re", ram_read_enable, 0);
    adv(); reset_n = 1; dn0 = id_n;
    run(8);
    chk("midrst_no_done", id_n - dn0, 0);

    // 6. back-to-back loads with mem_req held high
    hold_mem = 1; mem_req = 1; mem_we = 0; mem_addr = 32'h20; n = 0; g1 = 0; g2 = 0; d1 = 0;
    for (int i = 0; i < 30 && n < 2; i++) begin
      cyc_chk();
      if (mem_gnt) begin n++; if (n == 1) g1 = now; else g2 = now; end
      if (mem_done && n == 1) d1 = now;
      adv();
      if (n == 1) mem_addr = 32'h24;
      if (n == 2) mem_req = 0;
    end
    hold_mem = 0;
    chk("b2b_gnts", n, 2);
    chk("b2b_gap", g2 - d1, 1);
    chk("b2b_first_lat", d1 - g1, 4);
    run(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
